// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Pipeline sequencer for the 5-stage core (S1 IF, S2 ID, S3 RR, S4 EX, S5 MEM).
//   Generates the PC enable and the enable/flush pair of every inter-stage
//   latch. It handles load-use hazards, multi-cycle EX ops, memory
//   back-pressure and EX branch redirects. It also keeps a saturating
//   stall-cycle counter and a sticky multi-cycle watchdog flag.
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   s3_rs1/s3_rs2/s3_uses_rs2 source registers of the instruction in S3
//   s4_rd/s4_is_load          destination and load flag of the instruction in S4
//   s4_mc_start/ex_mc_done    multi-cycle op start (first EX cycle) / result valid
//   redirect                  taken branch/jump in S4
//   mem_busy                  S5 memory not ready, freezes the whole pipe
//   pc_en, en_*, fl_*         PC enable, latch enables, latch flushes
//   stall_cnt                 cycles with pc_en==0 (saturating)
//   mc_timeout                sticky: multi-cycle op exceeded MC_MAX_CYCLES
module pipe_hazard_ctrl #(
   parameter int unsigned CNT_W         = 32,
   parameter int unsigned MC_MAX_CYCLES = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       s3_rs1,
   input  logic [4:0]       s3_rs2,
   input  logic             s3_uses_rs2,
   input  logic [4:0]       s4_rd,
   input  logic             s4_is_load,
   input  logic             s4_mc_start,
   input  logic             ex_mc_done,
   input  logic             redirect,
   input  logic             mem_busy,
   output logic             pc_en,
   output logic             en_s1_s2,
   output logic             en_s2_s3,
   output logic             en_s3_s4,
   output logic             en_s4_s5,
   output logic             fl_s1_s2,
   output logic             fl_s2_s3,
   output logic             fl_s3_s4,
   output logic             fl_s4_s5,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             mc_timeout
);

   localparam int unsigned WD_W = $clog2(MC_MAX_CYCLES + 1);

   typedef enum logic {
      RUN     = 1'b0,
      MC_WAIT = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic              mc_timeout_q, mc_timeout_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic              load_use;

   // x0 is hard-wired zero, so a load targeting it never creates a hazard.
   always_comb begin
      load_use = s4_is_load && (s4_rd != 5'd0) &&
                 ((s4_rd == s3_rs1) || (s3_uses_rs2 && (s4_rd == s3_rs2)));
   end

   always_comb begin
      state_d      = state_q;
      wd_d         = wd_q;
      mc_timeout_d = mc_timeout_q;
      pc_en        = 1'b1;
      en_s1_s2     = 1'b1;
      en_s2_s3     = 1'b1;
      en_s3_s4     = 1'b1;
      en_s4_s5     = 1'b1;
      fl_s1_s2     = 1'b0;
      fl_s2_s3     = 1'b0;
      fl_s3_s4     = 1'b0;
      fl_s4_s5     = 1'b0;

      if (rst) begin
         pc_en    = 1'b0;
         en_s1_s2 = 1'b0;
         en_s2_s3 = 1'b0;
         en_s3_s4 = 1'b0;
         en_s4_s5 = 1'b0;
         fl_s1_s2 = 1'b1;
         fl_s2_s3 = 1'b1;
         fl_s3_s4 = 1'b1;
         fl_s4_s5 = 1'b1;
      end else if (mem_busy) begin
         // Full freeze; pending events are re-evaluated once memory is ready.
         pc_en    = 1'b0;
         en_s1_s2 = 1'b0;
         en_s2_s3 = 1'b0;
         en_s3_s4 = 1'b0;
         en_s4_s5 = 1'b0;
      end else if (state_q == MC_WAIT) begin
         if (ex_mc_done) begin
            state_d = RUN;
            wd_d    = '0;
         end else if (wd_q == WD_W'(MC_MAX_CYCLES)) begin
            // Watchdog expiry: the op leaves EX as-is, like a normal completion.
            mc_timeout_d = 1'b1;
            state_d      = RUN;
            wd_d         = '0;
         end else begin
            pc_en    = 1'b0;
            en_s1_s2 = 1'b0;
            en_s2_s3 = 1'b0;
            en_s3_s4 = 1'b0;
            fl_s4_s5 = 1'b1;
            wd_d     = wd_q + WD_W'(1);
         end
      end else if (s4_mc_start) begin
         pc_en    = 1'b0;
         en_s1_s2 = 1'b0;
         en_s2_s3 = 1'b0;
         en_s3_s4 = 1'b0;
         fl_s4_s5 = 1'b1;
         state_d  = MC_WAIT;
         wd_d     = WD_W'(1);
      end else if (redirect) begin
         // The S3 instruction is killed, so any load-use hazard on it is moot.
         fl_s1_s2 = 1'b1;
         fl_s2_s3 = 1'b1;
         fl_s3_s4 = 1'b1;
      end else if (load_use) begin
         pc_en    = 1'b0;
         en_s1_s2 = 1'b0;
         en_s2_s3 = 1'b0;
         fl_s3_s4 = 1'b1;
      end

      stall_cnt_d = stall_cnt_q;
      if (!rst && !pc_en && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RUN;
         wd_q         <= '0;
         mc_timeout_q <= 1'b0;
         stall_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         wd_q         <= wd_d;
         mc_timeout_q <= mc_timeout_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign mc_timeout = mc_timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Drives two sequencers (wide counter and a 4-bit counter to reach
//   saturation) from shared inputs and compares every cycle against a
//   behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

   localparam int unsigned MCMAX = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] s3_rs1, s3_rs2, s4_rd;
   logic       s3_uses_rs2, s4_is_load, s4_mc_start, ex_mc_done, redirect, mem_busy;

   logic        pc_en_a, e12_a, e23_a, e34_a, e45_a, f12_a, f23_a, f34_a, f45_a, to_a;
   logic [31:0] cnt_a;
   logic        pc_en_b, e12_b, e23_b, e34_b, e45_b, f12_b, f23_b, f34_b, f45_b, to_b;
   logic [3:0]  cnt_b;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.CNT_W(32), .MC_MAX_CYCLES(MCMAX)) dut_a (
      .clk(clk), .rst(rst), .s3_rs1(s3_rs1), .s3_rs2(s3_rs2), .s3_uses_rs2(s3_uses_rs2),
      .s4_rd(s4_rd), .s4_is_load(s4_is_load), .s4_mc_start(s4_mc_start),
      .ex_mc_done(ex_mc_done), .redirect(redirect), .mem_busy(mem_busy),
      .pc_en(pc_en_a), .en_s1_s2(e12_a), .en_s2_s3(e23_a), .en_s3_s4(e34_a), .en_s4_s5(e45_a),
      .fl_s1_s2(f12_a), .fl_s2_s3(f23_a), .fl_s3_s4(f34_a), .fl_s4_s5(f45_a),
      .stall_cnt(cnt_a), .mc_timeout(to_a));

   pipe_hazard_ctrl #(.CNT_W(4), .MC_MAX_CYCLES(MCMAX)) dut_b (
      .clk(clk), .rst(rst), .s3_rs1(s3_rs1), .s3_rs2(s3_rs2), .s3_uses_rs2(s3_uses_rs2),
      .s4_rd(s4_rd), .s4_is_load(s4_is_load), .s4_mc_start(s4_mc_start),
      .ex_mc_done(ex_mc_done), .redirect(redirect), .mem_busy(mem_busy),
      .pc_en(pc_en_b), .en_s1_s2(e12_b), .en_s2_s3(e23_b), .en_s3_s4(e34_b), .en_s4_s5(e45_b),
      .fl_s1_s2(f12_b), .fl_s2_s3(f23_b), .fl_s3_s4(f34_b), .fl_s4_s5(f45_b),
      .stall_cnt(cnt_b), .mc_timeout(to_b));

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: is a multi-cycle op outstanding, how many wait cycles
   // it has consumed, the sticky timeout and the stall totals.
   bit     m_mc_busy;
   int     m_waited;
   bit     m_to;
   longint m_cnt_a, m_cnt_b;

   task automatic tick();
      logic [8:0] exp_v, obs_a, obs_b;
      bit lu;
      bit advance;
      #1;
      lu = s4_is_load && (s4_rd != 0) &&
           ((s3_rs1 == s4_rd) || (s3_uses_rs2 && (s3_rs2 == s4_rd)));
      advance = 0;
      // Vector layout: {pc_en, en s1s2..s4s5, fl s1s2..s4s5}
      if (rst)                                           exp_v = 9'b0_0000_1111;
      else if (mem_busy)                                 exp_v = 9'b0_0000_0000;
      else if (m_mc_busy && (ex_mc_done || m_waited == MCMAX)) begin
         exp_v = 9'b1_1111_0000; advance = 1;
      end
      else if (m_mc_busy || s4_mc_start)                 exp_v = 9'b0_0001_0001;
      else if (redirect)                                 exp_v = 9'b1_1111_1110;
      else if (lu)                                       exp_v = 9'b0_0011_0010;
      else                                               exp_v = 9'b1_1111_0000;

      obs_a = {pc_en_a, e12_a, e23_a, e34_a, e45_a, f12_a, f23_a, f34_a, f45_a};
      obs_b = {pc_en_b, e12_b, e23_b, e34_b, e45_b, f12_b, f23_b, f34_b, f45_b};
      chk("ctl_a", 64'(obs_a), 64'(exp_v));
      chk("ctl_b", 64'(obs_b), 64'(exp_v));
      chk("stall_cnt_a", 64'(cnt_a), 64'(m_cnt_a));
      chk("stall_cnt_b", 64'(cnt_b), 64'(m_cnt_b));
      chk("mc_timeout_a", 64'(to_a), 64'(m_to));
      chk("mc_timeout_b", 64'(to_b), 64'(m_to));

      if (rst) begin
         m_mc_busy = 0; m_waited = 0; m_to = 0; m_cnt_a = 0; m_cnt_b = 0;
      end else begin
         if (!mem_busy) begin
            if (m_mc_busy) begin
               if (advance) begin
                  if (!ex_mc_done) m_to = 1;
                  m_mc_busy = 0; m_waited = 0;
               end else begin
                  m_waited++;
               end
            end else if (s4_mc_start) begin
               m_mc_busy = 1; m_waited = 1;
            end
         end
         if (exp_v[8] == 1'b0) begin
            if (m_cnt_a < 64'hFFFF_FFFF) m_cnt_a++;
            if (m_cnt_b < 15) m_cnt_b++;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle();
      rst = 0; s3_rs1 = 0; s3_rs2 = 0; s3_uses_rs2 = 0; s4_rd = 0; s4_is_load = 0;
      s4_mc_start = 0; ex_mc_done = 0; redirect = 0; mem_busy = 0;
   endtask

   task automatic do_reset();
      idle(); rst = 1; tick(); rst = 0;
   endtask

   initial begin
      m_mc_busy = 0; m_waited = 0; m_to = 0; m_cnt_a = 0; m_cnt_b = 0;
      idle();
      rst = 1;
      @(negedge clk);
      tick();
      tick();
      rst = 0;

      // Free run
      for (int i = 0; i < 10; i++) tick();
      chk("free_run_cnt", 64'(cnt_a), 64'd0);

      // Load-use on rs1, then x0 never hazards
      s4_is_load = 1; s4_rd = 5; s3_rs1 = 5; tick();
      idle(); tick();
      chk("lu_cnt", 64'(cnt_a), 64'd1);
      s4_is_load = 1; s4_rd = 0; s3_rs1 = 0; s3_rs2 = 0; s3_uses_rs2 = 1; tick();
      idle(); tick();
      chk("x0_cnt", 64'(cnt_a), 64'd1);

      // Multi-cycle op completing four cycles after start
      do_reset();
      s4_mc_start = 1; tick(); s4_mc_start = 0;
      for (int i = 0; i < 3; i++) tick();
      ex_mc_done = 1; tick(); ex_mc_done = 0;
      tick();
      chk("mc_cnt4", 64'(cnt_a), 64'd4);

      // Redirect beats load-use
      do_reset();
      s4_is_load = 1; s4_rd = 7; s3_rs2 = 7; s3_uses_rs2 = 1; redirect = 1; tick();
      idle(); tick();
      chk("redir_cnt", 64'(cnt_a), 64'd0);

      // mem_busy during MC_WAIT freezes the watchdog, then timeout
      do_reset();
      s4_mc_start = 1; tick(); s4_mc_start = 0;
      mem_busy = 1; for (int i = 0; i < 3; i++) tick(); mem_busy = 0;
      for (int i = 0; i < 7; i++) tick();
      chk("wd_frozen", 64'(to_a), 64'd0);
      tick();
      tick();
      chk("timeout_set", 64'(to_a), 64'd1);
      do_reset();
      tick();
      chk("timeout_clr", 64'(to_a), 64'd0);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         rst         = ($urandom_range(0, 99) < 2);
         mem_busy    = ($urandom_range(0, 99) < 15);
         s4_mc_start = ($urandom_range(0, 99) < 8);
         ex_mc_done  = ($urandom_range(0, 99) < 12);
         redirect    = ($urandom_range(0, 99) < 12);
         s4_is_load  = $urandom_range(0, 1);
         s3_uses_rs2 = $urandom_range(0, 1);
         s3_rs1      = 5'($urandom_range(0, 3));
         s3_rs2      = 5'($urandom_range(0, 3));
         s4_rd       = 5'($urandom_range(0, 3));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
